animation_sequencer: RTL and testbench
======================================

Name: animation_sequencer

Overview:
Frame/animation controller for the 7-segment display path. Steps a frame index at a programmable rate and wraps it at the per-animation frame limit. The limit comes from the external combinational limit lookup, which is driven by this block's animation output. Selects the animation by next/prev pulses (manual) or advances automatically after a set number of complete loops (auto).

Parameters:
DIV_W, 24, width of the frame-rate prescaler and of the period input
NUM_ANI, 64, number of animations; index wraps modulo NUM_ANI (must be ≤64)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; low freezes all state, outputs hold, pulses forced 0
period  in  DIV_W  frame period minus 1, in clk cycles
auto_mode  in  1  1 = auto-advance animations, 0 = manual
loops  in  4  complete loops per animation before auto-advance; 0 = never advance
pause  in  1  level; holds frame, prescaler and loop count
btn_next  in  1  single-cycle pulse (pre-debounced): next animation
btn_prev  in  1  single-cycle pulse (pre-debounced): previous animation
limit  in  5  frame count for current animation from lookup; 0 encodes 32
animation  out  6  current animation index
frame  out  5  current frame index, 0..limit_eff-1
frame_tick  out  1  one-cycle pulse coincident with a new frame value
loop_done  out  1  one-cycle pulse coincident with frame wrapping to 0 from the tick

Behaviour:
- Reset (rst_n=0 at posedge): animation=0, frame=0, frame_tick=0, loop_done=0, prescaler=0, loop_cnt=0, state=SWITCH.
- limit_eff = (limit==0) ? 32 : limit. A limit of 1 keeps frame at 0 but still ticks and loops.
- States:
  - SWITCH (1 cycle): frame, prescaler and loop_cnt cleared, which lets limit settle for the new animation. Next state: PAUSED if pause=1, else RUN.
  - RUN: prescaler increments each cycle. When prescaler==period, a tick occurs: prescaler clears and frame advances on that edge. frame_tick=1 in the following cycle with the new frame. period=0 gives a tick every cycle; otherwise a tick every period+1 cycles. pause=1 → PAUSED.
  - PAUSED: all counters hold, no pulses. pause=0 → RUN, resuming the prescaler from its held value.
- Tick in RUN:
  - If frame ≥ limit_eff-1, frame←0, loop_done=1 with the new frame, and loop_cnt←loop_cnt+1 (saturating at 15).
  - Otherwise frame←frame+1.
  - The ≥ compare also recovers when limit shrinks under a live frame.
- Auto-advance: on a wrap tick with auto_mode=1, loops≠0 and loop_cnt+1==loops, animation←(animation+1) mod NUM_ANI and state←SWITCH. frame_tick and loop_done still pulse for that wrap.
- Buttons:
  - Accepted in every state, including SWITCH and PAUSED.
  - btn_next: animation+1 mod NUM_ANI. btn_prev: animation-1 mod NUM_ANI (0→NUM_ANI-1). Either one forces state←SWITCH; PAUSED exits via SWITCH and re-enters PAUSED if pause is still 1.
  - Both buttons high in the same cycle: ignored.
  - Buttons act in auto_mode too; a button press restarts the loop count.
- Priority per cycle: rst_n > ena=0 (freeze) > button > pause > tick/auto-advance. A button in the same cycle as an auto-advance tick wins; the tick is dropped and produces no pulses.
- Changing period mid-run: the new value applies immediately. If the prescaler is already above the new period, it counts up and wraps at 2^DIV_W, then matches; this is defined behaviour, and the bench must not flag it.
- Reset mid-operation behaves identically to power-on reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then pause=0, auto_mode=0, period=3, limit=10 (ani0) → SWITCH for 1 cycle, then frame steps 0,1,…,9,0 every 4 clks; loop_done pulses with the 9→0 transition; animation stays 0.
- period=0, limit=0 (32-frame animation) → frame counts 0..31 on consecutive cycles, wraps to 0 after 31, loop_done once every 32 cycles.
- auto_mode=1, loops=2, animation=0, limit=10 → after 20 ticks animation=1 and frame=0, with one SWITCH cycle. With loops=0 → animation never changes.
- btn_prev at animation=0 → animation=63, frame=0. btn_next at 63 → 0. Both buttons in the same cycle → no change.
- pause=1 at frame=5 with prescaler mid-count for 50 cycles → frame, prescaler and pulses frozen; release → next tick after the remaining count; btn_next while paused → animation+1, frame=0, stays PAUSED.
- ena=0 for 10 cycles mid-run → all outputs held, frame_tick=0; rst_n=0 mid-run → all outputs 0 on the next edge and restart via SWITCH.

Source files
------------

// File: rtl/animation_sequencer.sv
// Frame/animation stepper for the 7-segment path: programmable frame rate, per-animation wrap, manual or auto select.
// All outputs registered; a button or auto-advance passes through one SWITCH cycle so the external limit lookup can settle.
module animation_sequencer #(
    parameter int DIV_W   = 24,
    parameter int NUM_ANI = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [DIV_W-1:0] period,
    input  logic             auto_mode,
    input  logic [3:0]       loops,
    input  logic             pause,
    input  logic             btn_next,
    input  logic             btn_prev,
    input  logic [4:0]       limit,
    output logic [5:0]       animation,
    output logic [4:0]       frame,
    output logic             frame_tick,
    output logic             loop_done
);

    typedef enum logic [1:0] {SWITCH, RUN, PAUSED} state_t;

    localparam logic [5:0] ANI_LAST = 6'(NUM_ANI - 1);

    state_t           state, state_nxt;
    logic [DIV_W-1:0] prescaler;
    logic [3:0]       loop_cnt;
    logic             btn, tick, wrap, advance;
    logic [4:0]       last_frame;
    logic [5:0]       ani_inc, ani_dec;

    // limit==0 encodes 32 frames, so limit-1 in 5 bits wraps naturally to 31
    assign last_frame = limit - 5'd1;
    assign btn        = btn_next ^ btn_prev;
    assign ani_inc    = (animation == ANI_LAST) ? 6'd0 : animation + 6'd1;
    assign ani_dec    = (animation == 6'd0) ? ANI_LAST : animation - 6'd1;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= SWITCH;
        else if (ena)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        wrap      = 1'b0;
        advance   = 1'b0;
        if (btn) begin
            state_nxt = SWITCH;
        end else begin
            case (state)
                SWITCH: state_nxt = pause ? PAUSED : RUN;
                RUN: begin
                    if (pause) begin
                        state_nxt = PAUSED;
                    end else if (prescaler == period) begin
                        tick    = 1'b1;
                        wrap    = (frame >= last_frame);
                        advance = wrap && auto_mode && (loops != 4'd0) &&
                                  ({1'b0, loop_cnt} + 5'd1 == {1'b0, loops});
                        if (advance)
                            state_nxt = SWITCH;
                    end
                end
                PAUSED: if (!pause) state_nxt = RUN;
                default: state_nxt = SWITCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            animation  <= 6'd0;
            frame      <= 5'd0;
            frame_tick <= 1'b0;
            loop_done  <= 1'b0;
            prescaler  <= '0;
            loop_cnt   <= 4'd0;
        end else if (!ena) begin
            frame_tick <= 1'b0;
            loop_done  <= 1'b0;
        end else begin
            frame_tick <= tick;
            loop_done  <= wrap;
            if (btn) begin
                animation <= btn_next ? ani_inc : ani_dec;
                frame     <= 5'd0;
                prescaler <= '0;
                loop_cnt  <= 4'd0;
            end else if (state == SWITCH) begin
                frame     <= 5'd0;
                prescaler <= '0;
                loop_cnt  <= 4'd0;
            end else if (state == RUN && !pause) begin
                if (tick) begin
                    prescaler <= '0;
                    frame     <= wrap ? 5'd0 : frame + 5'd1;
                    if (wrap && loop_cnt != 4'd15)
                        loop_cnt <= loop_cnt + 4'd1;
                    if (advance)
                        animation <= ani_inc;
                end else begin
                    // a prescaler already past a newly lowered period wraps at 2^DIV_W
                    prescaler <= prescaler + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_animation_sequencer.sv
// Bench for animation_sequencer: directed scenarios plus randomized traffic against a cycle reference model.
module tb_animation_sequencer;
    localparam int NUM   = 64;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             rst_n, ena, auto_mode, pause, btn_next, btn_prev;
    logic [DIV_W-1:0] period;
    logic [3:0]       loops;
    logic [4:0]       limit;
    logic [5:0]       animation;
    logic [4:0]       frame;
    logic             frame_tick, loop_done;
    logic [4:0]       lim_tab [NUM];

    always #5 clk = ~clk;

    // external combinational limit lookup, addressed by the DUT's animation output
    assign limit = lim_tab[animation];

    animation_sequencer #(.DIV_W(DIV_W), .NUM_ANI(NUM)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .period(period),
        .auto_mode(auto_mode), .loops(loops), .pause(pause),
        .btn_next(btn_next), .btn_prev(btn_prev), .limit(limit),
        .animation(animation), .frame(frame),
        .frame_tick(frame_tick), .loop_done(loop_done)
    );

    int checks = 0;
    int errors = 0;

    // reference: phase 0 = settling after a switch, 1 = counting, 2 = held
    int m_ani, m_frm, m_pre, m_loops_done, m_phase, m_tick, m_ld;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model();
        int frames;
        bit one_btn;
        frames  = (lim_tab[m_ani] == 0) ? 32 : int'(lim_tab[m_ani]);
        one_btn = (btn_next != btn_prev);
        if (!rst_n) begin
            m_ani = 0; m_frm = 0; m_pre = 0; m_loops_done = 0;
            m_phase = 0; m_tick = 0; m_ld = 0;
        end else if (!ena) begin
            m_tick = 0; m_ld = 0;
        end else begin
            m_tick = 0; m_ld = 0;
            if (one_btn) begin
                m_ani = btn_next ? (m_ani + 1) % NUM : (m_ani + NUM - 1) % NUM;
                m_frm = 0; m_pre = 0; m_loops_done = 0; m_phase = 0;
            end else if (m_phase == 0) begin
                m_frm = 0; m_pre = 0; m_loops_done = 0;
                m_phase = pause ? 2 : 1;
            end else if (m_phase == 2) begin
                if (!pause) m_phase = 1;
            end else if (pause) begin
                m_phase = 2;
            end else if (m_pre == int'(period)) begin
                m_pre = 0;
                m_tick = 1;
                if (m_frm >= frames - 1) begin
                    m_frm = 0;
                    m_ld = 1;
                    if (auto_mode && loops != 0 && m_loops_done + 1 == int'(loops)) begin
                        m_ani = (m_ani + 1) % NUM;
                        m_phase = 0;
                    end
                    m_loops_done = (m_loops_done >= 15) ? 15 : m_loops_done + 1;
                end else begin
                    m_frm = m_frm + 1;
                end
            end else begin
                m_pre = (m_pre + 1) % (1 << DIV_W);
            end
        end
    endtask

    task automatic step();
        model();
        @(posedge clk);
        #1;
        chk("animation", 32'(animation), 32'(m_ani));
        chk("frame", 32'(frame), 32'(m_frm));
        chk("frame_tick", 32'(frame_tick), 32'(m_tick));
        chk("loop_done", 32'(loop_done), 32'(m_ld));
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int ld_count;
        rst_n = 1'b0; ena = 1'b1; auto_mode = 1'b0; pause = 1'b0;
        btn_next = 1'b0; btn_prev = 1'b0; period = 24'd3; loops = 4'd0;
        foreach (lim_tab[i]) lim_tab[i] = 5'd10;
        #1;

        // reset values
        step();
        step();
        chk("rst_animation", 32'(animation), 0);
        chk("rst_frame", 32'(frame), 0);
        chk("rst_tick", 32'(frame_tick), 0);
        rst_n = 1'b1;

        // period 3, 10 frames
        ld_count = 0;
        repeat (82) begin
            step();
            if (loop_done) ld_count++;
        end
        chk("ld_count_p3", 32'(ld_count), 2);

        // period 0, 32 frames
        rst_n = 1'b0; step();
        period = 24'd0; lim_tab[0] = 5'd0; rst_n = 1'b1;
        ld_count = 0;
        repeat (65) begin
            step();
            if (loop_done) ld_count++;
        end
        chk("ld_count_32", 32'(ld_count), 2);

        // auto-advance after 2 loops of 10 frames
        rst_n = 1'b0; step();
        lim_tab[0] = 5'd10; auto_mode = 1'b1; loops = 4'd2; rst_n = 1'b1;
        run(20);
        chk("auto_before", 32'(animation), 0);
        run(1);
        chk("auto_after", 32'(animation), 1);
        chk("auto_frame", 32'(frame), 0);
        loops = 4'd0;
        run(100);
        chk("auto_loops0", 32'(animation), 1);

        // buttons and wrap of the animation index
        rst_n = 1'b0; step();
        auto_mode = 1'b0; rst_n = 1'b1;
        btn_prev = 1'b1; step(); btn_prev = 1'b0;
        chk("prev_wrap", 32'(animation), 63);
        run(3);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        chk("next_wrap", 32'(animation), 0);
        run(3);
        btn_next = 1'b1; btn_prev = 1'b1; step(); btn_next = 1'b0; btn_prev = 1'b0;
        chk("both_btn", 32'(animation), 0);
        run(5);

        // pause mid-count
        rst_n = 1'b0; step();
        period = 24'd9; rst_n = 1'b1;
        for (int i = 0; i < 200 && !(m_frm == 5 && m_pre == 4); i++) step();
        chk("pause_setup", 32'(m_frm), 5);
        pause = 1'b1;
        run(50);
        chk("pause_frame", 32'(frame), 5);
        pause = 1'b0;
        run(30);
        pause = 1'b1;
        run(3);
        btn_next = 1'b1; step(); btn_next = 1'b0;
        run(20);
        chk("pause_btn_ani", 32'(animation), 1);
        chk("pause_btn_frame", 32'(frame), 0);
        pause = 1'b0;
        run(25);

        // enable freeze, then reset mid-run
        ena = 1'b0;
        run(10);
        chk("ena_tick", 32'(frame_tick), 0);
        ena = 1'b1;
        run(10);
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_ani", 32'(animation), 0);
        chk("midrst_frame", 32'(frame), 0);
        run(20);

        // randomized traffic
        for (int r = 0; r < 8; r++) begin
            period    = 24'($urandom_range(0, 6));
            auto_mode = 1'($urandom_range(0, 1));
            loops     = 4'($urandom_range(0, 3));
            foreach (lim_tab[i]) lim_tab[i] = 5'($urandom_range(0, 31));
            pause = 1'b0; ena = 1'b1;
            do_reset();
            for (int c = 0; c < 400; c++) begin
                btn_next = 1'b0; btn_prev = 1'b0;
                if ($urandom_range(0, 19) == 0) btn_next = 1'b1;
                if ($urandom_range(0, 19) == 0) btn_prev = 1'b1;
                if ($urandom_range(0, 29) == 0) pause = ~pause;
                ena = ($urandom_range(0, 14) != 0);
                if ($urandom_range(0, 49) == 0) lim_tab[m_ani] = 5'($urandom_range(0, 31));
                step();
            end
            btn_next = 1'b0; btn_prev = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
